// File: rtl/ntt_pkg.sv
// Shared constants and types for the Kyber NTT butterfly scheduler.
package ntt_pkg;
    localparam int N          = 256;
    localparam int Q          = 3329;
    localparam int LOG_N      = 8;
    localparam int NUM_LAYERS = 7;

    typedef logic [LOG_N-1:0] coef_addr_t;
    typedef logic [6:0]       zeta_idx_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;
endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth valid+data shift register aligning issued butterflies with write-back.
module ntt_wb_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic         vld_q  [DEPTH];
    logic [W-1:0] data_q [DEPTH];

    // Cleared on reset so an aborted transform never emits a write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= vld_i;
            data_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];
endmodule

// File: rtl/ntt_bf_scheduler.sv
// Kyber forward-NTT sequencer: one butterfly issue per cycle over 7 layers,
// with a pipeline drain between layers and delayed write-back addresses.
module ntt_bf_scheduler #(
    parameter int N      = 256,
    parameter int BF_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           layer,
    output logic                 rd_en,
    output ntt_pkg::coef_addr_t  rd_addr_a,
    output ntt_pkg::coef_addr_t  rd_addr_b,
    output ntt_pkg::zeta_idx_t   zeta_idx,
    output logic                 wr_en,
    output ntt_pkg::coef_addr_t  wr_addr_a,
    output ntt_pkg::coef_addr_t  wr_addr_b
);
    import ntt_pkg::*;

    localparam logic [7:0] HALF_N     = 8'(N / 2);
    localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);

    sched_state_t state_q;
    logic [2:0]   layer_q;
    logic [6:0]   bf_cnt_q;
    logic [3:0]   drain_cnt_q;
    logic         busy_q;
    logic         done_q;

    logic         issue;
    logic [7:0]   len;
    logic [7:0]   group;
    logic [7:0]   offset;
    logic [7:0]   addr_a;
    logic [15:0]  wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            layer_q     <= 3'd0;
            bf_cnt_q    <= 7'd0;
            drain_cnt_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        layer_q  <= 3'd0;
                        bf_cnt_q <= 7'd0;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        bf_cnt_q <= bf_cnt_q + 7'd1;
                        if (bf_cnt_q == 7'd127) begin
                            drain_cnt_q <= 4'd0;
                            state_q     <= DRAIN;
                        end
                    end
                end
                // Drain length ignores stall: only the delay line must empty.
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        if (layer_q == LAST_LAYER) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            layer_q <= layer_q + 3'd1;
                            state_q <= ISSUE;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign issue = (state_q == ISSUE);
    assign rd_en = issue && !stall;
    assign busy  = busy_q;
    assign done  = done_q;
    assign layer = layer_q;

    // Addresses are forced to zero outside ISSUE so idle/reset outputs read 0.
    always_comb begin
        len       = HALF_N >> layer_q;
        group     = {1'b0, bf_cnt_q} >> (3'd7 - layer_q);
        offset    = {1'b0, bf_cnt_q} & (len - 8'd1);
        addr_a    = (group << (4'd8 - {1'b0, layer_q})) | offset;
        rd_addr_a = issue ? addr_a : '0;
        rd_addr_b = issue ? (addr_a + len) : '0;
        zeta_idx  = issue ? ((7'd1 << layer_q) + group[6:0]) : '0;
    end

    ntt_wb_delay #(
        .DEPTH (BF_LAT),
        .W     (16)
    ) u_wb_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (rd_en),
        .data_i ({rd_addr_a, rd_addr_b}),
        .vld_o  (wr_en),
        .data_o (wb_data)
    );

    assign wr_addr_a = wb_data[15:8];
    assign wr_addr_b = wb_data[7:0];
endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Directed bench for ntt_bf_scheduler with a reference-loop scoreboard on reads and write-backs.
`timescale 1ns/1ps
module tb_ntt_bf_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [2:0] layer;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] zeta_idx;

    ntt_bf_scheduler #(.N(256), .BF_LAT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .layer     (layer),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .zeta_idx  (zeta_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] k;
        logic [2:0] lay;
    } bf_t;

    typedef struct {
        int         due;
        logic [7:0] a;
        logic [7:0] b;
    } wb_t;

    bf_t exp_q[$];
    wb_t wr_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  done_cnt = 0;
    int  wr_seen = 0;
    int  rd_cnt = 0;
    int  touched [7][256];
    bit  sb_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outvec();
        return {18'b0, busy, done, layer, rd_en, rd_addr_a, rd_addr_b, zeta_idx,
                wr_en, wr_addr_a, wr_addr_b};
    endfunction

    // Reference Cooley-Tukey loop order of the Kyber forward NTT.
    task automatic fill_exp();
        int k = 1;
        int lay = 0;
        exp_q.delete();
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st = st + 2 * len) begin
                for (int j = st; j < st + len; j++)
                    exp_q.push_back('{a: 8'(j), b: 8'(j + len), k: 7'(k), lay: 3'(lay)});
                k++;
            end
            lay++;
        end
    endtask

    task automatic begin_run();
        fill_exp();
        wr_q.delete();
        rd_cnt = 0;
        for (int l = 0; l < 7; l++)
            for (int i = 0; i < 256; i++) touched[l][i] = 0;
        sb_en = 1'b1;
    endtask

    task automatic end_run(input int exp_done);
        int bad = 0;
        chk("exp_left", 64'(exp_q.size()), 64'd0);
        chk("wr_left", 64'(wr_q.size()), 64'd0);
        chk("rd_count", 64'(rd_cnt), 64'd896);
        for (int l = 0; l < 7; l++)
            for (int i = 0; i < 256; i++)
                if (touched[l][i] != 1) bad++;
        chk("touched_once", 64'(bad), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic goto(input int c);
        while ((cyc - t0) < c) @(negedge clk);
    endtask

    task automatic pulse_start_run();
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) wr_seen++;
        if (sb_en) begin
            if (rd_en) begin
                if (exp_q.size() == 0) begin
                    chk("rd_extra", 64'd1, 64'd0);
                end else begin
                    bf_t e;
                    e = exp_q.pop_front();
                    chk("sb_rd_a", 64'(rd_addr_a), 64'(e.a));
                    chk("sb_rd_b", 64'(rd_addr_b), 64'(e.b));
                    chk("sb_zeta", 64'(zeta_idx), 64'(e.k));
                    chk("sb_layer", 64'(layer), 64'(e.lay));
                    touched[e.lay][rd_addr_a]++;
                    touched[e.lay][rd_addr_b]++;
                    rd_cnt++;
                    wr_q.push_back('{due: cyc + 3, a: rd_addr_a, b: rd_addr_b});
                end
            end
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_extra", 64'd1, 64'd0);
                end else begin
                    wb_t w;
                    w = wr_q.pop_front();
                    chk("sb_wr_time", 64'(cyc), 64'(w.due));
                    chk("sb_wr_a", 64'(wr_addr_a), 64'(w.a));
                    chk("sb_wr_b", 64'(wr_addr_b), 64'(w.b));
                end
            end else if (wr_q.size() != 0 && wr_q[0].due == cyc) begin
                chk("wr_missing", 64'd0, 64'd1);
                void'(wr_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", outvec(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // Run 1: no stall, start pulses during busy and in the done cycle
        begin_run();
        pulse_start_run();
        chk("r1_c1_rd_en", {63'd0, rd_en}, 64'd1);
        chk("r1_c1_busy", {63'd0, busy}, 64'd1);
        chk("r1_c1_abk", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd0, 8'd128, 8'd1});
        goto(128);
        chk("r1_c128_abk", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd127, 8'd255, 8'd1});
        for (int c = 129; c <= 131; c++) begin
            goto(c);
            chk("r1_drain_rd_en", {63'd0, rd_en}, 64'd0);
        end
        goto(132);
        chk("r1_l1_first", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd0, 8'd64, 8'd2});
        chk("r1_l1_layer", 64'(layer), 64'd1);
        goto(196);
        chk("r1_l1_bf64", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd128, 8'd192, 8'd3});
        goto(300);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        goto(914);
        chk("r1_l6_last", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd253, 8'd255, 8'd127});
        chk("r1_l6_layer", 64'(layer), 64'd6);
        goto(917);
        chk("r1_c917_done", {63'd0, done}, 64'd0);
        goto(918);
        chk("r1_c918_done_busy_layer", {59'd0, done, busy, layer}, {59'd0, 1'b1, 1'b1, 3'd6});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("r1_c919_done_busy", {62'd0, done, busy}, 64'd0);
        goto(920);
        chk("r1_c920_no_restart", {62'd0, busy, rd_en}, 64'd0);
        end_run(1);

        // Run 2: started two cycles after done, 5-cycle stall mid layer 2
        begin_run();
        pulse_start_run();
        chk("r2_c1_abk", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd0, 8'd128, 8'd1});
        goto(299);
        @(posedge clk);
        #1 stall = 1'b1;
        for (int c = 300; c <= 304; c++) begin
            @(negedge clk);
            chk("r2_stall_rd_en", {63'd0, rd_en}, 64'd0);
            chk("r2_stall_a", 64'(rd_addr_a), 64'(exp_q[0].a));
            chk("r2_stall_b", 64'(rd_addr_b), 64'(exp_q[0].b));
            chk("r2_stall_k", 64'(zeta_idx), 64'(exp_q[0].k));
            chk("r2_stall_wr_en", {63'd0, wr_en}, (c <= 302) ? 64'd1 : 64'd0);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        goto(922);
        chk("r2_c922_done", {63'd0, done}, 64'd0);
        goto(923);
        chk("r2_c923_done", {63'd0, done}, 64'd1);
        goto(925);
        end_run(2);

        // Run 3: asynchronous reset mid-transform
        sb_en = 1'b0;
        exp_q.delete();
        wr_q.delete();
        pulse_start_run();
        goto(500);
        chk("r3_busy_before_rst", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("r3_async_rst_outputs", outvec(), 64'd0);
        begin
            int wr_seen0;
            wr_seen0 = wr_seen;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("r3_post_rst_idle", {60'd0, busy, done, rd_en, wr_en}, 64'd0);
            end
            goto(950);
            chk("r3_no_wb_after_rst", 64'(wr_seen - wr_seen0), 64'd0);
            chk("r3_no_done", 64'(done_cnt), 64'd2);
        end

        // Run 4: normal transform after reset release
        begin_run();
        pulse_start_run();
        chk("r4_c1_abk", {40'd0, rd_addr_a, rd_addr_b, 1'b0, zeta_idx}, {40'd0, 8'd0, 8'd128, 8'd1});
        goto(917);
        chk("r4_c917_done", {63'd0, done}, 64'd0);
        goto(918);
        chk("r4_c918_done", {63'd0, done}, 64'd1);
        goto(920);
        end_run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
